// File: rtl/l1_l2_arbiter_if.sv
// Bundle of the L1 I/D request ports and the shared L2 line port.
// The slave modport is the arbiter; the master modport is the L1/L2 side.
interface l1_l2_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata, l2_rdata, l2_resp,
        output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_address, l2_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata, l2_rdata, l2_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_address, l2_wdata
    );
endinterface

// File: rtl/l1_l2_arbiter.sv
// Arbitrates L1 I/D line misses and writebacks onto the single L2 line port.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed D-over-I priority.
module l1_l2_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int LINE_W   = 128,
    parameter int OFFSET_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    l1_l2_arbiter_if.slave   bus,
    output logic [CNT_W-1:0] i_grant_count,
    output logic [CNT_W-1:0] d_grant_count
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              l2_read_q, l2_read_d;
    logic              l2_write_q, l2_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
    logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;
    logic              i_resp, d_resp;
    logic              d_req, pick_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic              last_d_q, last_d_d;  // 1: D was granted most recently
`endif

    assign d_req = bus.d_read | bus.d_write;
`ifdef ARB_ROUND_ROBIN_EN
    assign pick_d = d_req & ~(bus.i_read & last_d_q);
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        state_d    = state_q;
        l2_read_d  = l2_read_q;
        l2_write_d = l2_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_cnt_d    = i_cnt_q;
        d_cnt_d    = d_cnt_q;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_d   = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d    = SERVE_D;
                    l2_write_d = bus.d_write;
                    l2_read_d  = ~bus.d_write;
                    addr_d     = {bus.d_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    if (bus.d_write) wdata_d = bus.d_wdata;
                    if (d_cnt_q != {CNT_W{1'b1}}) d_cnt_d = d_cnt_q + CNT_ONE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d   = 1'b1;
`endif
                end else if (bus.i_read) begin
                    state_d    = SERVE_I;
                    l2_write_d = 1'b0;
                    l2_read_d  = 1'b1;
                    addr_d     = {bus.i_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    if (i_cnt_q != {CNT_W{1'b1}}) i_cnt_d = i_cnt_q + CNT_ONE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d   = 1'b0;
`endif
                end
            end
            SERVE_I: begin
                if (bus.l2_resp) begin
                    i_resp     = 1'b1;
                    i_rdata_d  = bus.l2_rdata;
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                    state_d    = DONE;
                end
            end
            SERVE_D: begin
                if (bus.l2_resp) begin
                    d_resp     = 1'b1;
                    d_rdata_d  = bus.l2_rdata;
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_cnt_q    <= '0;
            d_cnt_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            l2_read_q  <= l2_read_d;
            l2_write_q <= l2_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_cnt_q    <= i_cnt_d;
            d_cnt_q    <= d_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q   <= last_d_d;
`endif
        end
    end

    // Response data bypasses the holding register in the l2_resp cycle.
    assign bus.i_resp     = i_resp;
    assign bus.d_resp     = d_resp;
    assign bus.i_rdata    = i_resp ? bus.l2_rdata : i_rdata_q;
    assign bus.d_rdata    = d_resp ? bus.l2_rdata : d_rdata_q;
    assign bus.l2_read    = l2_read_q;
    assign bus.l2_write   = l2_write_q;
    assign bus.l2_address = addr_q;
    assign bus.l2_wdata   = wdata_q;
    assign i_grant_count  = i_cnt_q;
    assign d_grant_count  = d_cnt_q;
endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter: inputs change on the falling edge, outputs checked 1 time unit later.
module tb_l1_l2_arbiter;
    logic        clk;
    logic        reset;
    logic [15:0] i_cnt;
    logic [15:0] d_cnt;
    int          n_tests;
    int          n_fail;
    logic [127:0] pat_a5, pat_3c, pat_c3, pat_w;
    logic        exp_d;

    l1_l2_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus ();

    l1_l2_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .i_grant_count (i_cnt),
        .d_grant_count (d_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        pat_a5  = {16{8'hA5}};
        pat_3c  = {16{8'h3C}};
        pat_c3  = {16{8'hC3}};
        pat_w   = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
        reset   = 1'b1;
        bus.i_read = 1'b0; bus.i_address = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
        bus.l2_rdata = '0; bus.l2_resp = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_l2_read", bus.l2_read, 0);
        chk("rst_l2_write", bus.l2_write, 0);
        chk("rst_l2_address", bus.l2_address, 0);
        chk("rst_l2_wdata", bus.l2_wdata, 0);
        chk("rst_resps", {bus.i_resp, bus.d_resp}, 0);
        chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        chk("rst_counts", {i_cnt, d_cnt}, 0);
        reset = 1'b0;

        // Single I read, L2 latency 3
        @(negedge clk); bus.i_read = 1'b1; bus.i_address = 16'h1236; #1;
        chk("t1_before_grant", bus.l2_read, 0);
        @(negedge clk); #1;
        chk("t1_l2_read", bus.l2_read, 1);
        chk("t1_l2_write", bus.l2_write, 0);
        chk("t1_l2_address", bus.l2_address, 16'h1230);
        chk("t1_i_count", i_cnt, 1);
        @(negedge clk); #1;
        chk("t1_hold", bus.l2_read, 1);
        @(negedge clk); bus.l2_resp = 1'b1; bus.l2_rdata = pat_a5; #1;
        chk("t1_i_resp", bus.i_resp, 1);
        chk("t1_i_rdata", bus.i_rdata, pat_a5);
        chk("t1_d_resp", bus.d_resp, 0);
        @(negedge clk); bus.l2_resp = 1'b0; bus.l2_rdata = '0; bus.i_read = 1'b0; #1;
        chk("t1_done_l2_read", bus.l2_read, 0);
        chk("t1_done_i_resp", bus.i_resp, 0);
        chk("t1_i_rdata_hold", bus.i_rdata, pat_a5);
        $display("[TB] txn I read addr=1236 done");
        @(negedge clk);

        // D writeback, inputs disturbed mid-grant, l2_resp in DONE and IDLE ignored
        @(negedge clk); bus.d_write = 1'b1; bus.d_address = 16'h00FF; bus.d_wdata = pat_w;
        @(negedge clk); #1;
        chk("t2_l2_write", bus.l2_write, 1);
        chk("t2_l2_read", bus.l2_read, 0);
        chk("t2_l2_address", bus.l2_address, 16'h00F0);
        chk("t2_l2_wdata", bus.l2_wdata, pat_w);
        bus.d_address = 16'hFFFF; bus.d_wdata = '1;
        @(negedge clk); #1;
        chk("t2_addr_stable", bus.l2_address, 16'h00F0);
        chk("t2_wdata_stable", bus.l2_wdata, pat_w);
        @(negedge clk); bus.l2_resp = 1'b1; bus.l2_rdata = pat_3c; #1;
        chk("t2_d_resp", bus.d_resp, 1);
        chk("t2_d_rdata", bus.d_rdata, pat_3c);
        chk("t2_i_resp_quiet", bus.i_resp, 0);
        chk("t2_i_rdata_hold", bus.i_rdata, pat_a5);
        @(negedge clk); bus.d_write = 1'b0; bus.l2_rdata = '0; #1;
        chk("t2_done_resp_ign", bus.d_resp, 0);
        chk("t2_done_no_req", {bus.l2_read, bus.l2_write}, 0);
        chk("t2_d_rdata_hold", bus.d_rdata, pat_3c);
        @(negedge clk); #1;
        chk("t2_idle_resp_ign", {bus.i_resp, bus.d_resp}, 0);
        chk("t2_idle_no_req", {bus.l2_read, bus.l2_write}, 0);
        chk("t2_d_count", d_cnt, 1);
        bus.l2_resp = 1'b0;
        $display("[TB] txn D write addr=00FF done");

`ifndef ARB_ROUND_ROBIN_EN
        // Contended reads: D first, I granted from the IDLE after D's DONE
        @(negedge clk); bus.i_read = 1'b1; bus.d_read = 1'b1;
        bus.i_address = 16'h2004; bus.d_address = 16'h300C;
        @(negedge clk); #1;
        chk("t3_d_first_read", bus.l2_read, 1);
        chk("t3_d_first_addr", bus.l2_address, 16'h3000);
        chk("t3_counts", {i_cnt, d_cnt}, {16'd1, 16'd2});
        bus.l2_resp = 1'b1; bus.l2_rdata = pat_c3; #1;
        chk("t3_d_resp", {bus.i_resp, bus.d_resp}, 2'b01);
        @(negedge clk); bus.l2_resp = 1'b0; bus.d_read = 1'b0; #1;
        chk("t3_done", bus.l2_read, 0);
        @(negedge clk); #1;
        chk("t3_idle", bus.l2_read, 0);
        @(negedge clk); #1;
        chk("t3_i_read", bus.l2_read, 1);
        chk("t3_i_addr", bus.l2_address, 16'h2000);
        chk("t3_i_count", i_cnt, 2);
        bus.l2_resp = 1'b1; #1;
        chk("t3_i_resp", {bus.i_resp, bus.d_resp}, 2'b10);
        chk("t3_i_rdata", bus.i_rdata, pat_c3);
        @(negedge clk); bus.l2_resp = 1'b0; bus.i_read = 1'b0;
        @(negedge clk);
        $display("[TB] txn contended D then I done");
`endif

        // Reset two cycles into an I read
        @(negedge clk); bus.i_read = 1'b1; bus.i_address = 16'h4444;
        @(negedge clk); #1;
        chk("t4_read_up", bus.l2_read, 1);
        @(negedge clk); #2; reset = 1'b1; bus.l2_resp = 1'b1; #1;
        chk("t4_async_l2_read", bus.l2_read, 0);
        chk("t4_no_resp", {bus.i_resp, bus.d_resp}, 0);
        chk("t4_counts", {i_cnt, d_cnt}, 0);
        chk("t4_addr_clr", bus.l2_address, 0);
        chk("t4_rdata_clr", {bus.i_rdata, bus.d_rdata}, 0);
        @(negedge clk); reset = 1'b0; bus.i_read = 1'b0; bus.l2_resp = 1'b0; #1;
        chk("t4_idle", bus.l2_read, 0);
        $display("[TB] txn reset mid-read done");

        // Four back-to-back contended reads from reset
        bus.i_read = 1'b1; bus.d_read = 1'b1;
        bus.i_address = 16'h1000; bus.d_address = 16'h2000;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            @(negedge clk); #1;
            chk("t5_grant_addr", bus.l2_address, exp_d ? 16'h2000 : 16'h1000);
            chk("t5_l2_read", bus.l2_read, 1);
            bus.l2_resp = 1'b1; #1;
            chk("t5_resp", {bus.i_resp, bus.d_resp}, exp_d ? 2'b01 : 2'b10);
            @(negedge clk); bus.l2_resp = 1'b0;
            if (k == 3) begin
                bus.i_read = 1'b0; bus.d_read = 1'b0;
            end
            @(negedge clk);
            $display("[TB] txn contended #%0d granted %s", k, exp_d ? "D" : "I");
        end
`ifdef ARB_ROUND_ROBIN_EN
        chk("t5_counts", {i_cnt, d_cnt}, {16'd2, 16'd2});
`else
        chk("t5_counts", {i_cnt, d_cnt}, {16'd0, 16'd4});
`endif

        // D counter saturation; read+write together is a write
        force dut.d_cnt_q = 16'hFFFF;
        @(negedge clk); release dut.d_cnt_q;
        bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_address = 16'h5555; bus.d_wdata = pat_w; #1;
        chk("t6_forced", d_cnt, 16'hFFFF);
        @(negedge clk); #1;
        chk("t6_saturated", d_cnt, 16'hFFFF);
        chk("t6_rw_is_write", {bus.l2_read, bus.l2_write}, 2'b01);
        chk("t6_addr", bus.l2_address, 16'h5550);
        bus.l2_resp = 1'b1; #1;
        chk("t6_d_resp", bus.d_resp, 1);
        @(negedge clk); bus.l2_resp = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
        @(negedge clk); #1;
        chk("t6_hold", d_cnt, 16'hFFFF);
        $display("[TB] txn D write at saturated count done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/l1_l2_arbiter.md
Name: l1_l2_arbiter

Overview:
- Arbitrates the split L1 instruction and data caches onto the single shared 128-bit line port of the unified L2.
- Grants one L1 miss/writeback at a time and latches that requester's line-aligned address and write data.
- Forwards L2 read data and response back to the granted requester only.
- Sits between the two L1 cache controllers and the L2 cache; the CPU datapath never sees it.

Parameters:
- ADDR_W, 16, byte-address width (lc3b_word).
- LINE_W, 128, L1 line width in bits (lc3b_mem_data).
- OFFSET_W, 4, L1 line-offset bits (width of lc3b_c_offset), zeroed on forwarded addresses.
- CNT_W, 16, width of the saturating grant counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_read  in  1  I-cache line read request.
- i_address  in  ADDR_W  I-cache request address.
- i_rdata  out  LINE_W  line returned to I-cache.
- i_resp  out  1  I-cache transaction complete.
- d_read  in  1  D-cache line read request.
- d_write  in  1  D-cache line writeback request.
- d_address  in  ADDR_W  D-cache request address.
- d_wdata  in  LINE_W  D-cache writeback line.
- d_rdata  out  LINE_W  line returned to D-cache.
- d_resp  out  1  D-cache transaction complete.
- l2_read  out  1  read request to L2.
- l2_write  out  1  write request to L2.
- l2_address  out  ADDR_W  line-aligned address to L2.
- l2_wdata  out  LINE_W  write line to L2.
- l2_rdata  in  LINE_W  L2 read data.
- l2_resp  in  1  L2 transaction complete.
- i_grant_count  out  CNT_W  saturating count of I grants.
- d_grant_count  out  CNT_W  saturating count of D grants.

Behaviour:
- Reset: asynchronous, active-high. Clears the FSM to IDLE, all latched registers, and both counters to 0.
- Reset values: l2_read/l2_write/i_resp/d_resp = 0; l2_address/l2_wdata = 0; i_rdata/d_rdata = 0.
- FSM states: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE: sample requests each cycle.
  - d_read|d_write present -> SERVE_D, even if i_read is also high (fixed D priority).
  - Else i_read -> SERVE_I.
  - On the grant edge, latch the following:
    - op: write = d_write, read otherwise;
    - address with bits [OFFSET_W-1:0] forced to 0;
    - d_wdata, for a D write only.
  - Increment the matching counter, saturating at all-ones (no wrap).
- SERVE_x:
  - l2_read/l2_write, l2_address and l2_wdata are driven from registers only; they are stable for the whole grant.
  - First L2 request cycle is the cycle after the requester's request is first seen (1-cycle grant latency).
  - Hold until l2_resp.
- Response forwarding: in the cycle l2_resp=1, combinationally assert the granted requester's resp and drive its rdata from l2_rdata. Then go to DONE.
  - Non-granted requester's resp stays 0 and its rdata holds its last value.
  - l2_read/l2_write drop on the edge leaving SERVE_x.
- DONE: one dead cycle with no L2 request and no sampling, so the just-served requester can deassert. Then go to IDLE.
  - Minimum back-to-back spacing: 1 grant cycle + L2 latency + 1 DONE cycle.
- d_read and d_write both high: treated as a write.
- Requests dropping before the grant: the request is never seen and no grant occurs.
- Requests changing during SERVE_x: ignored, since the latched values are used.
- l2_resp in IDLE or DONE: ignored; no resp is forwarded.
- Reset mid-transaction: abandons the transaction immediately, with no resp to either L1. The L2 must be reset concurrently.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both sides request in IDLE, grant the side not served last.
  - A last-grant flag is updated on each grant.
  - Reset value: last = I, so the first contended grant goes to D.
- Undefined: fixed D-over-I priority as above; no last-grant register exists.

Test Plan:
- Single I read: i_read=1, i_address=16'h1236, L2 latency 3 cycles with l2_rdata=128'hA5...A5.
  - Required: l2_read rises 1 cycle after the request is first seen, with l2_address=16'h1230.
  - Required: i_resp=1 with i_rdata=A5...A5 in the l2_resp cycle; d_resp stays 0; i_grant_count=1.
- D writeback: d_write=1, d_address=16'h00FF, d_wdata=128'h1234...
  - Required: l2_write=1, l2_address=16'h00F0, l2_wdata matches, stable until l2_resp.
  - Required: d_resp pulses for 1 cycle, then 1 DONE cycle with no L2 request.
- Simultaneous i_read and d_read (macro off): D served first.
  - Required: I is granted on the IDLE cycle after D's DONE.
- Simultaneous requests with the macro on, 4 consecutive contended transactions.
  - Required grant order: D, I, D, I.
- Reset asserted 2 cycles into an L2 read.
  - Required: l2_read=0 and FSM in IDLE asynchronously; no resp pulse; counters = 0.
- Force d_grant_count to 16'hFFFF, then one more D grant.
  - Required: count holds at 16'hFFFF.
